core_scheduler: RTL and testbench

Sequences the accelerator compute cores through a run: it launches a masked subset of cores, collects their per-core done indications, and detects completion or timeout. It drives the 2-bit phase code consumed by the GPIO status block, using the encoding 0=IDLE, 1=START_CORES, 2=WAIT_FOR_DONE, 3=DONE_STATE. It sits between the host/top-level control and the core array.

---
 rtl/core_scheduler_pkg.sv | 20 ++
 rtl/sched_timeout_ctr.sv | 38 +++
 rtl/core_scheduler.sv | 130 +++++++++++++
 tb/tb_core_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_scheduler_pkg
// Purpose  : Phase encoding and default core count for the core scheduler.
// Revision : 1.0
// ============================================================================
package core_scheduler_pkg;

    // Phase codes are also decoded by the GPIO status block.
    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        START_CORES   = 2'd1,
        WAIT_FOR_DONE = 2'd2,
        DONE_STATE    = 2'd3
    } phase_e;

    localparam int DEFAULT_NUM_CORES = 4;

endpackage
`default_nettype wire

// File: rtl/sched_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : sched_timeout_ctr
// Purpose  : Saturating wait-cycle counter flagging the last permitted cycle.
// Revision : 1.0
// ============================================================================
module sched_timeout_ctr #(
    parameter int                   TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TIMEOUT_W-1:0] c_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] c_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] c_LAST = TIMEOUT_CYCLES - c_ONE;

    logic [TIMEOUT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != c_MAX)) begin
            r_count <= r_count + c_ONE;
        end
    end

    // A zero limit disables the timeout entirely.
    assign o_expired = (TIMEOUT_CYCLES != '0) && i_en && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/core_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : core_scheduler
// Purpose  : Launches a masked set of cores, gathers done, detects timeout.
// Revision : 1.0
// ============================================================================
module core_scheduler
    import core_scheduler_pkg::*;
#(
    parameter int                   NUM_CORES      = DEFAULT_NUM_CORES,
    parameter int                   TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic                 ack,
    input  logic [NUM_CORES-1:0] core_done,
    output logic [NUM_CORES-1:0] core_start,
    output logic [1:0]           phase,
    output logic                 busy,
    output logic [NUM_CORES-1:0] done_mask,
    output logic                 all_done,
    output logic                 timeout_err
);

    phase_e               r_state,       w_state_nxt;
    logic [NUM_CORES-1:0] r_active,      w_active_nxt;
    logic [NUM_CORES-1:0] r_core_start,  w_core_start_nxt;
    logic [NUM_CORES-1:0] r_done_mask,   w_done_mask_nxt;
    logic                 r_busy,        w_busy_nxt;
    logic                 r_all_done,    w_all_done_nxt;
    logic                 r_timeout_err, w_timeout_err_nxt;
    logic [NUM_CORES-1:0] w_seen;
    logic                 w_in_wait;
    logic                 w_expired;

    assign w_seen    = r_done_mask | (core_done & r_active);
    assign w_in_wait = (r_state == WAIT_FOR_DONE);

    sched_timeout_ctr #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (!w_in_wait),
        .i_en      (w_in_wait),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_active_nxt      = r_active;
        w_core_start_nxt  = '0;
        w_done_mask_nxt   = r_done_mask;
        w_busy_nxt        = 1'b0;
        w_all_done_nxt    = 1'b0;
        w_timeout_err_nxt = r_timeout_err;
        case (r_state)
            IDLE: begin
                if (start && (|core_mask)) begin
                    w_state_nxt       = START_CORES;
                    w_active_nxt      = core_mask;
                    w_done_mask_nxt   = '0;
                    w_timeout_err_nxt = 1'b0;
                    w_core_start_nxt  = core_mask;
                    w_busy_nxt        = 1'b1;
                end
            end
            START_CORES: begin
                w_state_nxt     = WAIT_FOR_DONE;
                w_done_mask_nxt = w_seen;
                w_busy_nxt      = 1'b1;
            end
            WAIT_FOR_DONE: begin
                w_done_mask_nxt = w_seen;
                w_busy_nxt      = 1'b1;
                // Completion takes priority over a coincident timeout.
                if (w_seen == r_active) begin
                    w_state_nxt    = DONE_STATE;
                    w_all_done_nxt = 1'b1;
                    w_busy_nxt     = 1'b0;
                end else if (w_expired) begin
                    w_state_nxt       = DONE_STATE;
                    w_timeout_err_nxt = 1'b1;
                    w_busy_nxt        = 1'b0;
                end
            end
            DONE_STATE: begin
                if (ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_active      <= '0;
            r_core_start  <= '0;
            r_done_mask   <= '0;
            r_busy        <= 1'b0;
            r_all_done    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_active      <= w_active_nxt;
            r_core_start  <= w_core_start_nxt;
            r_done_mask   <= w_done_mask_nxt;
            r_busy        <= w_busy_nxt;
            r_all_done    <= w_all_done_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign phase       = r_state;
    assign core_start  = r_core_start;
    assign busy        = r_busy;
    assign done_mask   = r_done_mask;
    assign all_done    = r_all_done;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_scheduler
// Purpose  : Directed self-checking bench for core_scheduler with a run model.
// Revision : 1.0
// ============================================================================
module tb_core_scheduler;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] core_mask;
    logic       ack;
    logic [3:0] core_done;
    logic [3:0] core_start;
    logic [1:0] phase;
    logic       busy;
    logic [3:0] done_mask;
    logic       all_done;
    logic       timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    core_scheduler #(
        .NUM_CORES      (4),
        .TIMEOUT_W      (16),
        .TIMEOUT_CYCLES (16'd8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .core_mask   (core_mask),
        .ack         (ack),
        .core_done   (core_done),
        .core_start  (core_start),
        .phase       (phase),
        .busy        (busy),
        .done_mask   (done_mask),
        .all_done    (all_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Run-level model: a run is accepted, launched, collects done bits and
    // ends either when every active core has reported or after T wait cycles.
    int         m_phase;
    int         m_waits;
    logic [3:0] m_active, m_dmask, m_cstart;
    logic       m_busy, m_all, m_to;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_waits = 0; m_active = 0; m_dmask = 0;
            m_cstart = 0; m_busy = 0; m_all = 0; m_to = 0;
        end else begin
            m_cstart = 0;
            m_all    = 0;
            case (m_phase)
                0: if (start && core_mask != 0) begin
                    m_active = core_mask; m_dmask = 0; m_to = 0;
                    m_cstart = core_mask; m_busy = 1; m_phase = 1;
                end
                1: begin
                    m_dmask = m_dmask | (core_done & m_active);
                    m_waits = 0; m_phase = 2;
                end
                2: begin
                    m_waits++;
                    m_dmask = m_dmask | (core_done & m_active);
                    if (m_dmask == m_active) begin
                        m_phase = 3; m_all = 1; m_busy = 0;
                    end else if (m_waits >= T) begin
                        m_phase = 3; m_to = 1; m_busy = 0;
                    end
                end
                default: if (ack) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("phase",       32'(phase),       32'(m_phase[1:0]));
            chk("core_start",  32'(core_start),  32'(m_cstart));
            chk("busy",        32'(busy),        32'(m_busy));
            chk("done_mask",   32'(done_mask),   32'(m_dmask));
            chk("all_done",    32'(all_done),    32'(m_all));
            chk("timeout_err", 32'(timeout_err), 32'(m_to));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input logic [3:0] m);
        start = 1'b1; core_mask = m;
        tick(1);
        start = 1'b0; core_mask = 4'h0;
    endtask

    task automatic release_done();
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("lit_ack_idle", 32'(phase), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b1; start = 1'b0; core_mask = 4'h0; ack = 1'b0; core_done = 4'h0;
        #1 rst_n = 1'b0;
        tick(2);
        chk("lit_rst_phase", 32'(phase), 32'd0);
        chk("lit_rst_cstart", 32'(core_start), 32'd0);
        chk("lit_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick(2);

        // Full mask launch, then complete everything in the first wait cycle.
        launch(4'hF);
        chk("lit_t1_phase1", 32'(phase), 32'd1);
        chk("lit_t1_cstart", 32'(core_start), 32'hF);
        chk("lit_t1_busy", 32'(busy), 32'd1);
        tick(1);
        chk("lit_t1_phase2", 32'(phase), 32'd2);
        chk("lit_t1_cstart0", 32'(core_start), 32'h0);
        core_done = 4'hF;
        tick(1);
        core_done = 4'h0;
        chk("lit_t1_all", 32'(all_done), 32'd1);
        release_done();
        tick(1);

        // Pulsed done on cores 0 and 2, noise on inactive cores.
        launch(4'b0101);
        tick(1);
        for (int w = 1; w <= 7; w++) begin
            core_done = (w == 3) ? 4'b0001 : (w == 5) ? 4'b1010 : (w == 7) ? 4'b0100 : 4'b0000;
            tick(1);
        end
        core_done = 4'h0;
        chk("lit_t2_phase3", 32'(phase), 32'd3);
        chk("lit_t2_dmask", 32'(done_mask), 32'b0101);
        chk("lit_t2_all", 32'(all_done), 32'd1);
        tick(2);
        chk("lit_t2_hold", 32'(done_mask), 32'b0101);
        release_done();
        tick(1);

        // Inactive done bits held high: only bit 0 counts, run times out.
        start = 1'b1; core_mask = 4'b0011;
        tick(1);
        start = 1'b0; core_mask = 4'h0; core_done = 4'b1101;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (phase != 2'd3 && n < 20);
        chk("lit_t3_waitlen", 32'(n), 32'd9);
        chk("lit_t3_to", 32'(timeout_err), 32'd1);
        chk("lit_t3_dmask", 32'(done_mask), 32'b0001);
        core_done = 4'h0;
        release_done();
        tick(1);

        // Last core reports exactly on the timeout cycle: completion wins.
        launch(4'b0011);
        chk("lit_t4_toclr", 32'(timeout_err), 32'd0);
        tick(1);
        for (int w = 1; w <= T; w++) begin
            core_done = (w == 2) ? 4'b0001 : (w == T) ? 4'b0010 : 4'b0000;
            tick(1);
        end
        core_done = 4'h0;
        chk("lit_t4_all", 32'(all_done), 32'd1);
        chk("lit_t4_to", 32'(timeout_err), 32'd0);
        release_done();
        tick(1);

        // Empty mask ignored; start while busy or in DONE_STATE ignored.
        launch(4'b0000);
        chk("lit_t5_empty", 32'(phase), 32'd0);
        launch(4'b1000);
        tick(2);
        launch(4'b1111);
        core_done = 4'b1000;
        tick(1);
        core_done = 4'h0;
        chk("lit_t5_done", 32'(phase), 32'd3);
        launch(4'b1111);
        start = 1'b1; ack = 1'b1; core_mask = 4'b1111;
        tick(1);
        start = 1'b0; ack = 1'b0; core_mask = 4'h0;
        chk("lit_t5_ackstart", 32'(phase), 32'd0);
        tick(1);
        chk("lit_t5_nolaunch", 32'(core_start), 32'd0);
        tick(2);

        // Asynchronous reset in the middle of a wait.
        launch(4'b1111);
        tick(2);
        core_done = 4'b0011;
        #2 rst_n = 1'b0;
        #1;
        chk("lit_t6_phase", 32'(phase), 32'd0);
        chk("lit_t6_dmask", 32'(done_mask), 32'd0);
        chk("lit_t6_busy", 32'(busy), 32'd0);
        core_done = 4'h0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("lit_t6_after", 32'(core_start), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
